// File: rtl/fas_pkg.sv
// Shared types and sizes for the FFT peak detector: bin format, magnitude width, FSM states.
package fas_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned BINS  = 16;
    localparam int unsigned MAG_W = 2 * DW;
    localparam int unsigned IDX_W = $clog2(BINS);

    // Packed so that a 32-bit frame word maps directly onto {re, im}.
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } fft_bin_t;

    typedef enum logic [0:0] {
        IDLE,
        SCAN
    } state_e;

endpackage

// File: rtl/fft_peak_detector_if.sv
// FFT frame input plus peak-result outputs between the analyser and the peak detector.
// FAS_PEAK_MAG_EN adds the peak_mag result signal.
interface fft_peak_detector_if;
    import fas_pkg::*;

    logic             fft_valid;
    logic [31:0]      fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
    logic [31:0]      fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
    logic [IDX_W-1:0] freq;
    logic             done;
    logic             busy;
    logic             overrun;
`ifdef FAS_PEAK_MAG_EN
    logic [MAG_W-1:0] peak_mag;
`endif

    modport master (
`ifdef FAS_PEAK_MAG_EN
        input  peak_mag,
`endif
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        input  freq, done, busy, overrun
    );

    modport slave (
`ifdef FAS_PEAK_MAG_EN
        output peak_mag,
`endif
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        output freq, done, busy, overrun
    );

endinterface

// File: rtl/fas_cmag.sv
// Combinational magnitude-squared of one complex bin: re^2 + im^2, unsigned, full width.
module fas_cmag
    import fas_pkg::*;
(
    input  fft_bin_t         bin,
    output logic [MAG_W-1:0] mag
);

    logic signed [MAG_W-1:0] re_ext, im_ext;
    logic signed [MAG_W-1:0] sq_re, sq_im;

    // Sign-extend first so each square is exact in MAG_W bits; the sum tops out at 2^31.
    assign re_ext = MAG_W'(bin.re);
    assign im_ext = MAG_W'(bin.im);
    assign sq_re  = re_ext * re_ext;
    assign sq_im  = im_ext * im_ext;
    assign mag    = MAG_W'(sq_re + sq_im);

endmodule

// File: rtl/fft_peak_detector.sv
// Captures a 16-bin FFT frame and scans it one bin per cycle, reporting the peak bin index.
// FAS_PEAK_MAG_EN also reports the winning bin's magnitude-squared on peak_mag.
module fft_peak_detector
    import fas_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fft_peak_detector_if.slave bus
);

    state_e           state_q, state_d;
    fft_bin_t         bin_q [BINS];
    fft_bin_t         frame [BINS];
    logic [IDX_W-1:0] idx_q, best_idx_q, freq_q;
    logic [MAG_W-1:0] best_mag_q, mag;
    logic             done_q, overrun_q;
    logic             last, load, drop, win;
`ifdef FAS_PEAK_MAG_EN
    logic [MAG_W-1:0] peak_mag_q;
`endif

    assign frame[0]  = fft_bin_t'(bus.fft_d0);
    assign frame[1]  = fft_bin_t'(bus.fft_d1);
    assign frame[2]  = fft_bin_t'(bus.fft_d2);
    assign frame[3]  = fft_bin_t'(bus.fft_d3);
    assign frame[4]  = fft_bin_t'(bus.fft_d4);
    assign frame[5]  = fft_bin_t'(bus.fft_d5);
    assign frame[6]  = fft_bin_t'(bus.fft_d6);
    assign frame[7]  = fft_bin_t'(bus.fft_d7);
    assign frame[8]  = fft_bin_t'(bus.fft_d8);
    assign frame[9]  = fft_bin_t'(bus.fft_d9);
    assign frame[10] = fft_bin_t'(bus.fft_d10);
    assign frame[11] = fft_bin_t'(bus.fft_d11);
    assign frame[12] = fft_bin_t'(bus.fft_d12);
    assign frame[13] = fft_bin_t'(bus.fft_d13);
    assign frame[14] = fft_bin_t'(bus.fft_d14);
    assign frame[15] = fft_bin_t'(bus.fft_d15);

    fas_cmag u_cmag (
        .bin (bin_q[idx_q]),
        .mag (mag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.fft_valid) state_d = SCAN;
            SCAN:    if (last && !bus.fft_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A frame is accepted when idle or on the final scan cycle, giving gap-free back-to-back frames.
    always_comb begin
        last = (state_q == SCAN) && (idx_q == IDX_W'(BINS - 1));
        load = bus.fft_valid && ((state_q == IDLE) || last);
        drop = bus.fft_valid && (state_q == SCAN) && !last;
        win  = (state_q == SCAN) && (mag > best_mag_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '{default: '0};
            idx_q      <= '0;
            best_mag_q <= '0;
            best_idx_q <= '0;
            freq_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q    <= last;
            overrun_q <= drop;
            if (load) begin
                bin_q      <= frame;
                idx_q      <= '0;
                best_mag_q <= '0;
                best_idx_q <= '0;
            end else if (state_q == SCAN) begin
                idx_q <= idx_q + 1'b1;
                if (win) begin
                    best_mag_q <= mag;
                    best_idx_q <= idx_q;
                end
            end
            if (last) begin
                freq_q <= win ? idx_q : best_idx_q;
            end
        end
    end

`ifdef FAS_PEAK_MAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_mag_q <= '0;
        end else if (last) begin
            peak_mag_q <= win ? mag : best_mag_q;
        end
    end

    assign bus.peak_mag = peak_mag_q;
`endif

    assign bus.freq    = freq_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == SCAN);
    assign bus.overrun = overrun_q;

endmodule
